// File: rtl/sobel_frame_scheduler.sv
// sobel_frame_scheduler: walks a frame through the free-running Sobel datapath and writes border and gradient rows
module sobel_frame_scheduler #(
  parameter int ROW_W = 10,
  parameter int RD_LAT = 1,
  parameter int PIPE_LAT = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [ROW_W-1:0] height,
  output logic             rd_en,
  output logic [ROW_W-1:0] rd_addr,
  output logic             out_we,
  output logic [ROW_W-1:0] out_addr,
  output logic             out_zero,
  output logic             busy,
  output logic             done,
  output logic             err
);
  localparam int L = RD_LAT + PIPE_LAT;
  typedef enum logic [2:0] {IDLE, TOP, FEED, DRAIN, BOT, DONE} state_t;
  state_t state;
  logic [ROW_W-1:0] h;
  logic [L-2:0] tag_v;
  logic [ROW_W-1:0] tag_i [L-1];
  // tag stages plus the out_we register form the L-cycle latency from rd_en to write
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      h <= '0;
      tag_v <= '0;
      for (int i = 0; i < L-1; i++) tag_i[i] <= '0;
      rd_en <= 1'b0;
      rd_addr <= '0;
      out_we <= 1'b0;
      out_addr <= '0;
      out_zero <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
    end else begin
      for (int i = 1; i < L-1; i++) begin
        tag_v[i] <= tag_v[i-1];
        tag_i[i] <= tag_i[i-1];
      end
      tag_v[0] <= rd_en && rd_addr >= ROW_W'(2);
      tag_i[0] <= rd_addr - ROW_W'(1);
      out_we <= tag_v[L-2];
      out_addr <= tag_i[L-2];
      out_zero <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
      case (state)
        IDLE:
          if (start && height >= ROW_W'(3)) begin
            h <= height;
            state <= TOP;
            out_we <= 1'b1;
            out_zero <= 1'b1;
            out_addr <= '0;
            busy <= 1'b1;
          end else if (start) err <= 1'b1;
        TOP: begin
          state <= FEED;
          rd_en <= 1'b1;
          rd_addr <= '0;
        end
        FEED:
          if (rd_addr == h - ROW_W'(1)) begin
            rd_en <= 1'b0;
            state <= DRAIN;
          end else rd_addr <= rd_addr + ROW_W'(1);
        DRAIN:
          if (tag_v == '0) begin
            state <= BOT;
            out_we <= 1'b1;
            out_zero <= 1'b1;
            out_addr <= h - ROW_W'(1);
          end
        BOT: begin
          state <= DONE;
          busy <= 1'b0;
          done <= 1'b1;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_sobel_frame_scheduler.sv
// tb_sobel_frame_scheduler: directed frames with a cycle-stamped scoreboard of expected strobes
module tb_sobel_frame_scheduler;
  localparam int L = 6;
  logic clk = 0, rst = 0, start = 0;
  logic [9:0] height = '0;
  logic rd_en, out_we, out_zero, busy, done, err;
  logic [9:0] rd_addr, out_addr;
  int cyc = 0, passed = 0, total = 0;

  typedef struct packed {int c; int a; logic z;} ev_t;
  ev_t wq[$], rq[$], dq[$], eq[$];

  sobel_frame_scheduler dut (
    .clk(clk), .rst(rst), .start(start), .height(height), .rd_en(rd_en), .rd_addr(rd_addr),
    .out_we(out_we), .out_addr(out_addr), .out_zero(out_zero), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic void push_frame(input int t, input int h);
    wq.push_back('{t+1, 0, 1'b1});
    for (int k = 0; k < h; k++) rq.push_back('{t+2+k, k, 1'b0});
    for (int r = 1; r <= h-2; r++) wq.push_back('{t+3+r+L, r, 1'b0});
    wq.push_back('{t+2+h+L, h-1, 1'b1});
    dq.push_back('{t+3+h+L, 0, 1'b0});
  endfunction

  always @(negedge clk) if (!rst) begin
    ev_t e;
    if (out_we === 1'b1) begin
      if (wq.size() == 0) chk("unexpected_write", 1, 0);
      else begin
        e = wq.pop_front();
        chk("wr_cycle", cyc, e.c);
        chk("wr_addr", int'(out_addr), e.a);
        chk("wr_zero", int'(out_zero), int'(e.z));
      end
    end
    if (rd_en === 1'b1) begin
      if (rq.size() == 0) chk("unexpected_rd", 1, 0);
      else begin
        e = rq.pop_front();
        chk("rd_cycle", cyc, e.c);
        chk("rd_addr", int'(rd_addr), e.a);
      end
    end
    if (done === 1'b1) begin
      if (dq.size() == 0) chk("unexpected_done", 1, 0);
      else begin e = dq.pop_front(); chk("done_cycle", cyc, e.c); end
    end
    if (err === 1'b1) begin
      if (eq.size() == 0) chk("unexpected_err", 1, 0);
      else begin e = eq.pop_front(); chk("err_cycle", cyc, e.c); end
    end
  end

  function automatic int pending();
    return wq.size() + rq.size() + dq.size() + eq.size();
  endfunction

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget && pending() > 0; i++) @(negedge clk);
    if (pending() > 0) begin
      chk("timeout_pending", pending(), 0);
      wq.delete(); rq.delete(); dq.delete(); eq.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic run_frame(input int h);
    int t;
    @(negedge clk);
    t = cyc;
    push_frame(t, h);
    start = 1; height = 10'(h);
    @(negedge clk);
    start = 0;
    wait_idle(h + L + 20);
  endtask

  initial begin
    int t;
    repeat (2) @(negedge clk);
    #3 rst = 1;
    #1 chk("reset_outputs", int'({rd_en, out_we, out_zero, busy, done, err, rd_addr, out_addr}), 0);
    repeat (2) @(negedge clk);
    rst = 0;
    repeat (2) @(negedge clk);
    chk("idle_busy", int'(busy), 0);

    run_frame(5);
    run_frame(3);

    @(negedge clk);
    t = cyc;
    eq.push_back('{t+1, 0, 1'b0});
    start = 1; height = 10'd2;
    @(negedge clk);
    start = 0;
    chk("reject_busy", int'(busy), 0);
    wait_idle(10);

    @(negedge clk);
    t = cyc;
    push_frame(t, 6);
    start = 1; height = 10'd6;
    @(negedge clk);
    start = 0;
    while (cyc < t+4) @(negedge clk);
    start = 1; height = 10'd4;
    @(negedge clk);
    start = 0;
    wait_idle(40);

    @(negedge clk);
    t = cyc;
    wq.push_back('{t+1, 0, 1'b1});
    for (int k = 0; k < 4; k++) rq.push_back('{t+2+k, k, 1'b0});
    start = 1; height = 10'd8;
    @(negedge clk);
    start = 0;
    while (cyc < t+5) @(negedge clk);
    #2 rst = 1;
    #1 chk("abort_outputs", int'({rd_en, out_we, busy, done}), 0);
    repeat (2) @(negedge clk);
    rst = 0;
    repeat (14) @(negedge clk);
    chk("abort_pending", pending(), 0);
    run_frame(4);

    @(negedge clk);
    t = cyc;
    push_frame(t, 5);
    push_frame(t+4+5+L, 5);
    start = 1; height = 10'd5;
    while (cyc < t+4+5+L) @(negedge clk);
    chk("gap_tags_empty", int'(dut.tag_v), 0);
    chk("gap_busy", int'(busy), 0);
    while (cyc < t+5+5+L) @(negedge clk);
    start = 0;
    wait_idle(40);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
